// File: rtl/updown_chk_pkg.sv
// Shared definitions for the up/down counter step checker: FSM states, direction
// encoding and the expected-next-value helper.
package updown_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    CHECK = 2'd2,
    ERROR = 2'd3
  } chk_state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Callers truncate the result to their count width, which gives the modulo wrap.
  function automatic logic [31:0] next_expected(input logic [31:0] prev, input logic dir);
    return (dir == DIR_DN) ? prev - 32'd1 : prev + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of rolling over.
module sat_counter #(
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [WRAP_W-1:0] value
);

  logic [WRAP_W-1:0] r_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else if (inc && (r_value != '1)) begin
      r_value <= r_value + WRAP_W'(1);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/updown_count_checker.sv
// Monitors an up/down counter: every sample must be one step from the previous one in
// the previously sampled direction. Reports step/init errors, legal wraps and direction flips.
module updown_count_checker
  import updown_chk_pkg::*;
#(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned WRAP_W      = 8,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic [WIDTH-1:0]  cnt,
  output logic              step_err,
  output logic              init_err,
  output logic              err_sticky,
  output logic [WRAP_W-1:0] err_cnt,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              dir_change,
  output logic [1:0]        state
);

  chk_state_e       r_state;
  logic [WIDTH-1:0] r_prev_cnt;
  logic             r_prev_sel;
  logic             r_step_err;
  logic             r_init_err;
  logic             r_sticky;
  logic             r_wrap;
  logic             r_dir_change;

  logic [WIDTH-1:0] w_exp;
  logic             w_in_arm;
  logic             w_in_check;
  logic             w_mismatch;
  logic             w_init_bad;
  logic             w_wrap_up;
  logic             w_wrap_dn;
  logic             w_wrap_legal;
  logic             w_err_inc;

  assign w_exp      = WIDTH'(next_expected(32'(r_prev_cnt), r_prev_sel));
  assign w_in_arm   = (r_state == ARM);
  assign w_in_check = (r_state == CHECK);
  assign w_mismatch = w_in_check && (cnt != w_exp);
  assign w_init_bad = w_in_arm && (cnt != '0);

  assign w_wrap_up    = (r_prev_sel == DIR_UP) && (r_prev_cnt == '1) && (cnt == '0);
  assign w_wrap_dn    = (r_prev_sel == DIR_DN) && (r_prev_cnt == '0) && (cnt == '1);
  // A mismatched step is never credited as a wrap.
  assign w_wrap_legal = w_in_check && !w_mismatch && (w_wrap_up || w_wrap_dn);
  assign w_err_inc    = w_mismatch || w_init_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_prev_cnt   <= '0;
      r_prev_sel   <= 1'b0;
      r_step_err   <= 1'b0;
      r_init_err   <= 1'b0;
      r_sticky     <= 1'b0;
      r_wrap       <= 1'b0;
      r_dir_change <= 1'b0;
    end else begin
      r_step_err   <= 1'b0;
      r_init_err   <= 1'b0;
      r_wrap       <= 1'b0;
      r_dir_change <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state <= ARM;
        end
        ARM: begin
          r_prev_cnt <= cnt;
          r_prev_sel <= sel;
          r_init_err <= w_init_bad;
          r_sticky   <= r_sticky | w_init_bad;
          r_state    <= CHECK;
        end
        CHECK: begin
          r_step_err   <= w_mismatch;
          r_wrap       <= w_wrap_legal;
          r_dir_change <= (sel != r_prev_sel);
          r_sticky     <= r_sticky | w_mismatch;
          // Realign on the observed value so one bad step gives exactly one error.
          r_prev_cnt   <= cnt;
          r_prev_sel   <= sel;
          r_state      <= (w_mismatch && STOP_ON_ERR) ? ERROR : CHECK;
        end
        ERROR: begin
          r_state <= ERROR;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  sat_counter #(
    .WRAP_W (WRAP_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_err_inc),
    .value (err_cnt)
  );

  sat_counter #(
    .WRAP_W (WRAP_W)
  ) u_wrap_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_wrap_legal),
    .value (wrap_cnt)
  );

  assign step_err   = r_step_err;
  assign init_err   = r_init_err;
  assign err_sticky = r_sticky;
  assign wrap       = r_wrap;
  assign dir_change = r_dir_change;
  assign state      = r_state;

endmodule

// File: tb/tb_updown_count_checker.sv
// Scoreboard bench: two checkers (realign / stop-on-error) watch the same counter stream;
// an arithmetic reference model predicts every cycle's outputs.
module tb_updown_count_checker;

  localparam int WIDTH  = 3;
  localparam int WRAP_W = 8;
  localparam int MOD    = 1 << WIDTH;
  localparam int MAXC   = (1 << WRAP_W) - 1;

  typedef struct packed {
    logic [1:0]        state;
    logic              step_err;
    logic              init_err;
    logic              sticky;
    logic [WRAP_W-1:0] err_cnt;
    logic              wrap;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              dir_change;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic [WIDTH-1:0] cnt = '0;

  logic              se0, ie0, sk0, w0, dc0, se1, ie1, sk1, w1, dc1;
  logic [WRAP_W-1:0] ec0, wc0, ec1, wc1;
  logic [1:0]        st0, st1;
  obs_t              a0, a1;

  always #5 clk = ~clk;

  updown_count_checker #(.WIDTH(WIDTH), .WRAP_W(WRAP_W), .STOP_ON_ERR(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .sel(sel), .cnt(cnt), .step_err(se0), .init_err(ie0),
    .err_sticky(sk0), .err_cnt(ec0), .wrap(w0), .wrap_cnt(wc0), .dir_change(dc0),
    .state(st0)
  );

  updown_count_checker #(.WIDTH(WIDTH), .WRAP_W(WRAP_W), .STOP_ON_ERR(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .sel(sel), .cnt(cnt), .step_err(se1), .init_err(ie1),
    .err_sticky(sk1), .err_cnt(ec1), .wrap(w1), .wrap_cnt(wc1), .dir_change(dc1),
    .state(st1)
  );

  assign a0 = {st0, se0, ie0, sk0, ec0, w0, wc0, dc0};
  assign a1 = {st1, se1, ie1, sk1, ec1, w1, wc1, dc1};

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  obs_t q0[$];
  obs_t q1[$];

  // Reference model state; phase uses the documented 0..3 state numbering.
  int m_phase[2], m_prev[2], m_psel[2], m_errs[2], m_wraps[2], m_sticky[2];

  // Bench-side counter feeding the checkers.
  int cur_cnt = 0;
  int cur_sel = 0;

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cycle, act, exp);
    end
  endtask

  task automatic model_step(input int k, input bit r, input bit s, input int c, input bit stop);
    obs_t e;
    int   want;
    e = '0;
    if (r) begin
      m_phase[k] = 0; m_prev[k] = 0; m_psel[k] = 0;
      m_errs[k] = 0; m_wraps[k] = 0; m_sticky[k] = 0;
    end else begin
      case (m_phase[k])
        0: m_phase[k] = 1;
        1: begin
          if (c != 0) begin
            e.init_err = 1'b1;
            m_sticky[k] = 1;
            if (m_errs[k] < MAXC) m_errs[k]++;
          end
          m_prev[k] = c; m_psel[k] = s; m_phase[k] = 2;
        end
        2: begin
          want = (m_prev[k] + (m_psel[k] != 0 ? MOD - 1 : 1)) % MOD;
          if (c != want) begin
            e.step_err = 1'b1;
            m_sticky[k] = 1;
            if (m_errs[k] < MAXC) m_errs[k]++;
            if (stop) m_phase[k] = 3;
          end else if ((m_psel[k] == 0 && m_prev[k] == MOD - 1 && c == 0) ||
                       (m_psel[k] == 1 && m_prev[k] == 0 && c == MOD - 1)) begin
            e.wrap = 1'b1;
            if (m_wraps[k] < MAXC) m_wraps[k]++;
          end
          e.dir_change = (int'(s) != m_psel[k]);
          m_prev[k] = c; m_psel[k] = s;
        end
        default: ;
      endcase
    end
    e.state    = 2'(m_phase[k]);
    e.sticky   = (m_sticky[k] != 0);
    e.err_cnt  = WRAP_W'(m_errs[k]);
    e.wrap_cnt = WRAP_W'(m_wraps[k]);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // One clock of stimulus; the expected result of the coming edge is queued.
  task automatic drive(input bit r, input bit s, input int c);
    @(posedge clk);
    #2;
    rst = r;
    sel = s;
    cnt = WIDTH'(c);
    model_step(0, r, s, c, 1'b0);
    model_step(1, r, s, c, 1'b1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0);
    cur_cnt = 0;
    cur_sel = 0;
  endtask

  // IDLE->ARM edge, then the ARM sample of first_cnt.
  task automatic arm(input int first_cnt);
    drive(1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, first_cnt);
    cur_cnt = first_cnt;
    cur_sel = 0;
  endtask

  // Real counter behaviour: the step taken uses the direction of the previous cycle.
  task automatic count(input int n, input bit s);
    for (int i = 0; i < n; i++) begin
      cur_cnt = (cur_cnt + (cur_sel != 0 ? MOD - 1 : 1)) % MOD;
      cur_sel = s;
      drive(1'b0, s, cur_cnt);
    end
  endtask

  // Monitor: every edge yields one output word per checker.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        checks++;
        if (a0 !== e) begin
          failures++;
          $display("FAIL sb_realign at cycle %0d: got %h expected %h", cycle, a0, e);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checks++;
        if (a1 !== e) begin
          failures++;
          $display("FAIL sb_stop at cycle %0d: got %h expected %h", cycle, a1, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, c;
    // Counting up, then down.
    do_reset(2);
    arm(0);
    count(20, 1'b0);
    count(1, 1'b1);
    check_val("wrap_cnt_after_up", int'(wc0), 2);
    check_val("sticky_after_up", int'(sk0), 0);
    count(19, 1'b1);
    count(1, 1'b1);
    check_val("wrap_cnt_after_down", int'(wc0), 4);
    check_val("err_cnt_clean", int'(ec0), 0);

    // Forced 0,1,2,4,5,6: one bad step.
    do_reset(1);
    arm(0);
    drive(1'b0, 1'b0, 1);
    drive(1'b0, 1'b0, 2);
    drive(1'b0, 1'b0, 4);
    drive(1'b0, 1'b0, 5);
    drive(1'b0, 1'b0, 6);
    check_val("realign_err_cnt", int'(ec0), 1);
    check_val("realign_sticky", int'(sk0), 1);
    check_val("stop_state", int'(st1), 3);
    check_val("stop_err_cnt", int'(ec1), 1);
    cur_cnt = 6;
    count(10, 1'b0);
    do_reset(1);
    drive(1'b0, 1'b0, 0);
    check_val("stop_reset_state", int'(st1), 0);
    check_val("stop_reset_err_cnt", int'(ec1), 0);

    // Bad first sample, then normal stepping from it, then mid-run reset.
    drive(1'b0, 1'b0, 5);
    cur_cnt = 5;
    cur_sel = 0;
    count(19, 1'b0);
    count(1, 1'b0);
    check_val("init_err_cnt", int'(ec0), 1);
    check_val("pre_reset_wrap_cnt", int'(wc0), 3);
    do_reset(1);
    drive(1'b0, 1'b0, 0);
    check_val("mid_reset_outputs", int'(a0), 0);
    drive(1'b0, 1'b0, 0);
    cur_cnt = 0;
    cur_sel = 0;
    count(12, 1'b0);

    // Randomised: direction flips, glitches and occasional resets.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_reset(1);
        arm((r == 0) ? int'($urandom_range(0, MOD - 1)) : 0);
      end else if (r < 8) begin
        c = int'($urandom_range(0, MOD - 1));
        cur_sel = int'($urandom_range(0, 1));
        cur_cnt = c;
        drive(1'b0, cur_sel[0], c);
      end else begin
        count(1, ($urandom_range(0, 4) == 0) ? ~cur_sel[0] : cur_sel[0]);
      end
    end

    // Error counter saturation: every step is +3.
    do_reset(1);
    arm(0);
    for (int i = 0; i < 300; i++) begin
      cur_cnt = (cur_cnt + 3) % MOD;
      drive(1'b0, 1'b0, cur_cnt);
    end
    count(1, 1'b0);
    check_val("err_cnt_saturated", int'(ec0), MAXC);

    // Wrap counter saturation.
    do_reset(1);
    arm(0);
    count(2100, 1'b0);
    count(1, 1'b0);
    check_val("wrap_cnt_saturated", int'(wc0), MAXC);

    repeat (3) @(posedge clk);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
